blink_sched: RTL and testbench

- Round-robin scheduler that shares one blinking LED between NREQ requesters.
- Each requester asks for a number of blinks. The block grants one requester at a time and runs the on/off phase counter for that many blinks.
- It pulses done to the owner when the sequence ends, then re-arbitrates.
- Sits between status/alert sources and the board LED pin.

---
 rtl/blink_sched.sv | 158 +++++++++++++++
 tb/tb_blink_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_sched.sv
// Round-robin owner of one blinking LED: grants a requester, runs its blink count, pulses done.
// Optional macro BLINK_SCHED_ABORT_EN adds an abort input that cuts a running sequence short.
module blink_sched #(
  parameter int NREQ  = 4,
  parameter int CBITS = 12,
  parameter int NBITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef BLINK_SCHED_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] blinks,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  led,
  output logic                  busy,
  output logic                  flg
);

  localparam int PBITS = $clog2(NREQ);
  localparam logic [CBITS-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ON   = 4'b0010,
    S_OFF  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CBITS-1:0] r_cnt, w_cnt_nxt;
  logic [NBITS-1:0] r_rem, w_rem_nxt;
  logic [PBITS-1:0] r_ptr, w_ptr_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]  r_done;
  logic             r_flg;

  logic             w_found;
  logic [PBITS-1:0] w_idx;
  logic [PBITS-1:0] w_win;
  logic [NREQ-1:0]  w_win_oh;
  logic [NBITS-1:0] w_win_blinks;
  logic [NBITS-1:0] w_blk [NREQ];
  logic             w_wrap;
  logic             w_abort;

`ifdef BLINK_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_blk
    assign w_blk[i] = blinks[i*NBITS +: NBITS];
  end

  // Scan from the highest offset down so the request nearest to ptr is the last one written.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = PBITS'((int'(r_ptr) + k) % NREQ);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_oh     = NREQ'(1) << w_win;
  assign w_win_blinks = w_blk[w_win];
  assign w_wrap       = (r_cnt == CNT_MAX);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = w_win_oh;
          w_rem_nxt   = w_win_blinks;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = (w_win == PBITS'(NREQ - 1)) ? '0 : w_win + PBITS'(1);
          w_state_nxt = (w_win_blinks != '0) ? S_ON : S_DONE;
        end
      end
      S_ON: begin
        if (w_abort) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CBITS'(1);
          if (w_wrap) w_state_nxt = S_OFF;
        end
      end
      S_OFF: begin
        if (w_abort) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CBITS'(1);
          if (w_wrap) begin
            if (r_rem > NBITS'(1)) begin
              w_rem_nxt   = r_rem - NBITS'(1);
              w_state_nxt = S_ON;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // flg and done are registered from next-state values so they line up with the wrap/DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_flg   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= (w_state_nxt == S_DONE) ? w_gnt_nxt : '0;
      r_flg   <= ((w_state_nxt == S_ON) || (w_state_nxt == S_OFF)) && (w_cnt_nxt == CNT_MAX);
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign flg  = r_flg;
  assign led  = r_state[1];
  assign busy = ~r_state[0];

endmodule

// File: tb/tb_blink_sched.sv
// Self-checking bench for blink_sched: directed scenarios plus random traffic against a
// transaction-level model (owner, blink count, cycles since grant).
module tb_blink_sched;

  localparam int NREQ  = 4;
  localparam int CBITS = 2;
  localparam int NBITS = 3;
  localparam int P     = 1 << CBITS;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  abort = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*NBITS-1:0] blinks = '0;
  logic [NREQ-1:0]       gnt, done;
  logic                  led, busy, flg;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: idle, or a sequence of m_len cycles starting at the grant cycle (m_t = 0).
  int m_act = 0, m_owner = 0, m_n = 0, m_t = 0, m_len = 0, m_ptr = 0;

  int on_cyc, done_cyc, nled, nflg, ngnt, k, gap;
  logic [NREQ-1:0] dv, prev;
  logic [NREQ-1:0] t2_exp [5];

  blink_sched #(.NREQ(NREQ), .CBITS(CBITS), .NBITS(NBITS)) u_dut (
    .clk    (clk),
    .rst    (rst),
`ifdef BLINK_SCHED_ABORT_EN
    .abort  (abort),
`endif
    .req    (req),
    .blinks (blinks),
    .gnt    (gnt),
    .done   (done),
    .led    (led),
    .busy   (busy),
    .flg    (flg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int slice_of(input int i);
    logic [NBITS-1:0] s;
    s = blinks[i*NBITS +: NBITS];
    return int'(s);
  endfunction

  task automatic model_reset();
    m_act = 0;
    m_ptr = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_advance();
    if (m_act != 0) begin
`ifdef BLINK_SCHED_ABORT_EN
      if (abort && (m_t < m_len - 1)) m_len = m_t + 2;
`endif
      if (m_t == m_len - 1) m_act = 0;
      else m_t++;
    end else begin
      for (int j = 0; j < NREQ; j++) begin
        int w;
        w = (m_ptr + j) % NREQ;
        if (req[w]) begin
          m_act   = 1;
          m_owner = w;
          m_n     = slice_of(w);
          m_len   = (m_n == 0) ? 1 : 2 * m_n * P + 1;
          m_t     = 0;
          m_ptr   = (w + 1) % NREQ;
          break;
        end
      end
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] eg, ed;
    logic el, ef;
    eg = '0; ed = '0; el = 1'b0; ef = 1'b0;
    if (m_act != 0) begin
      eg = NREQ'(1) << m_owner;
      if (m_t == m_len - 1) ed = eg;
      else begin
        el = (m_t % (2 * P)) < P;
        ef = (m_t % P) == P - 1;
      end
    end
    check("gnt",  gnt,  eg);
    check("done", done, ed);
    check("led",  led,  el);
    check("busy", busy, m_act != 0);
    check("flg",  flg,  ef);
  endtask

  // Called at a falling edge with inputs set up for the next rising edge.
  task automatic step();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    abort = 1'b0;
    #1;
    check("rst_gnt",  gnt,  0);
    check("rst_done", done, 0);
    check("rst_led",  led,  0);
    check("rst_busy", busy, 0);
    check("rst_flg",  flg,  0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain(input int budget);
    req = '0;
    abort = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_act == 0 && !busy) break;
      step();
    end
    check("drain_busy", busy, 0);
  endtask

  initial begin
    t2_exp[0] = 4'b0001; t2_exp[1] = 4'b0010; t2_exp[2] = 4'b0100;
    t2_exp[3] = 4'b1000; t2_exp[4] = 4'b0001;

    @(negedge clk);
    apply_reset();

    // Single requester, three blinks.
    blinks = '0;
    blinks[0 +: NBITS] = 3'd3;
    req = 4'b0001;
    step();
    check("t1_gnt", gnt, 4'b0001);
    req = '0;
    on_cyc = -1; done_cyc = -1; nled = 0; nflg = 0; dv = '0;
    for (int i = 0; i < 60; i++) begin
      if (led && on_cyc < 0) on_cyc = cyc;
      if (led) nled++;
      if (flg) nflg++;
      if (done != '0) begin
        done_cyc = cyc;
        dv = done;
        break;
      end
      step();
    end
    check("t1_latency", done_cyc - on_cyc, 2 * 3 * P);
    check("t1_led_cycles", nled, 3 * P);
    check("t1_flg_pulses", nflg, 6);
    check("t1_done", dv, 4'b0001);
    drain(10);

    // All four requesting, one blink each: strict rotation from ptr=0.
    apply_reset();
    blinks = {NREQ{3'd1}};
    req = '1;
    k = 0; gap = 0; prev = gnt;
    for (int i = 0; i < 200 && k < 5; i++) begin
      step();
      if (gnt != '0 && prev == '0) begin
        check("t2_order", gnt, t2_exp[k]);
        if (k > 0) check("t2_idle_gap", gap, 1);
        k++;
        gap = 0;
      end else if (gnt == '0) begin
        gap++;
      end
      prev = gnt;
    end
    check("t2_grants", k, 5);
    drain(40);

    // Zero-blink request: one-cycle grant, done, LED stays dark.
    blinks = '0;
    req = 4'b0100;
    step();
    req = '0;
    ngnt = 0; nled = 0; dv = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt != '0) ngnt++;
      if (led) nled++;
      if (done != '0) dv = done;
      step();
    end
    check("t3_gnt_cycles", ngnt, 1);
    check("t3_led_cycles", nled, 0);
    check("t3_done", dv, 4'b0100);

    // Request dropped and blinks changed after grant: original two blinks still run.
    blinks = '0;
    blinks[NBITS +: NBITS] = 3'd2;
    req = 4'b0010;
    step();
    req = '0;
    blinks = '1;
    nled = 0; dv = '0;
    for (int i = 0; i < 40; i++) begin
      if (led) nled++;
      if (done != '0) begin
        dv = done;
        break;
      end
      step();
    end
    check("t4_led_cycles", nled, 2 * P);
    check("t4_done", dv, 4'b0010);
    drain(10);

    // Asynchronous reset in the middle of ON; pointer must return to 0.
    blinks = '0;
    blinks[NBITS +: NBITS] = 3'd5;
    req = 4'b0010;
    step();
    req = '0;
    step();
    step();
    check("t5_on_before_rst", led, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_led",  led,  0);
    check("t5_rst_gnt",  gnt,  0);
    check("t5_rst_busy", busy, 0);
    @(negedge clk);
    check("t5_rst_done", done, 0);
    rst = 1'b0;
    model_reset();
    req = 4'b0110;
    step();
    check("t5_ptr0", gnt, 4'b0010);
    drain(60);

`ifdef BLINK_SCHED_ABORT_EN
    // Abort during the second ON cycle.
    blinks = '0;
    blinks[0 +: NBITS] = 3'd3;
    req = 4'b0001;
    step();
    req = '0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_led", led, 0);
    check("ab_done", done, 4'b0001);
    step();
    check("ab_idle_busy", busy, 0);
    drain(10);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) blinks[r*NBITS +: NBITS] = NBITS'($urandom_range(0, 3));
`ifdef BLINK_SCHED_ABORT_EN
      abort = ($urandom_range(0, 40) == 0);
`endif
      step();
    end
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
